// File: rtl/dec_fpr_wb_ctl.sv
// dec_fpr_wb_ctl
//   Write-side controller for the FP register file. Merges three fixed-latency
//   sources (fp0, fp1, ld) and the long-latency divide/sqrt result onto the
//   three register-file write ports. It also tracks in-flight divide
//   destinations in a 32-entry busy scoreboard so decode can stall dependents.
//
// Ports
//   clk, rst              core clock, synchronous active-high reset
//   fp0_*/fp1_*/ld_*      fast sources, no backpressure (fp0->port0,
//                         fp1->port1, ld->port2)
//   div_valid/waddr/wd    pending divide result; div_ready acks it
//   div_issue(_waddr)     divide issued at decode, marks destination busy
//   div_kill              flush: drops all busy bits and the starvation state
//   busy                  per-FPR pending-divide scoreboard
//   wb_stall              asks decode to keep fp1 idle so the divide can drain
//   wenN/waddrN/wdN       registered register-file write ports
module dec_fpr_wb_ctl #(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fp0_wen,
   input  logic [4:0]  fp0_waddr,
   input  logic [31:0] fp0_wd,
   input  logic        fp1_wen,
   input  logic [4:0]  fp1_waddr,
   input  logic [31:0] fp1_wd,
   input  logic        ld_wen,
   input  logic [4:0]  ld_waddr,
   input  logic [31:0] ld_wd,
   input  logic        div_valid,
   input  logic [4:0]  div_waddr,
   input  logic [31:0] div_wd,
   output logic        div_ready,
   input  logic        div_issue,
   input  logic [4:0]  div_issue_waddr,
   input  logic        div_kill,
   output logic [31:0] busy,
   output logic        wb_stall,
   output logic        wen0,
   output logic        wen1,
   output logic        wen2,
   output logic [4:0]  waddr0,
   output logic [4:0]  waddr1,
   output logic [4:0]  waddr2,
   output logic [31:0] wd0,
   output logic [31:0] wd1,
   output logic [31:0] wd2
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic             wen0_q, wen1_q, wen2_q, wen0_d, wen1_d, wen2_d;
   logic [4:0]       waddr0_q, waddr1_q, waddr2_q, waddr0_d, waddr1_d, waddr2_d;
   logic [31:0]      wd0_q, wd1_q, wd2_q, wd0_d, wd1_d, wd2_d;
   logic [31:0]      busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stall_q, stall_d;

   logic hs, waw, div_wr, div_p0, div_p1, div_p2;
   logic [31:0] set_vec, clr_vec;

   // Divide arbitration: any free port grants; a kill or reset blocks the ack.
   always_comb begin
      div_ready = div_valid & ~div_kill & ~rst & (~fp0_wen | ~fp1_wen | ~ld_wen);
      hs        = div_ready;
      // A same-cycle fast write to the same FPR is younger, so the divide
      // result is consumed but dropped.
      waw    = (fp0_wen && (fp0_waddr == div_waddr)) ||
               (fp1_wen && (fp1_waddr == div_waddr)) ||
               (ld_wen  && (ld_waddr  == div_waddr));
      div_wr = hs & ~waw;
      // Lowest-numbered free port takes the divide.
      div_p0 = div_wr & ~fp0_wen;
      div_p1 = div_wr &  fp0_wen & ~fp1_wen;
      div_p2 = div_wr &  fp0_wen &  fp1_wen & ~ld_wen;
   end

   // Write-port next state; address/data hold when the port is idle.
   always_comb begin
      wen0_d   = fp0_wen | div_p0;
      wen1_d   = fp1_wen | div_p1;
      wen2_d   = ld_wen  | div_p2;
      waddr0_d = waddr0_q;
      waddr1_d = waddr1_q;
      waddr2_d = waddr2_q;
      wd0_d    = wd0_q;
      wd1_d    = wd1_q;
      wd2_d    = wd2_q;
      if (fp0_wen) begin
         waddr0_d = fp0_waddr; wd0_d = fp0_wd;
      end else if (div_p0) begin
         waddr0_d = div_waddr; wd0_d = div_wd;
      end
      if (fp1_wen) begin
         waddr1_d = fp1_waddr; wd1_d = fp1_wd;
      end else if (div_p1) begin
         waddr1_d = div_waddr; wd1_d = div_wd;
      end
      if (ld_wen) begin
         waddr2_d = ld_waddr; wd2_d = ld_wd;
      end else if (div_p2) begin
         waddr2_d = div_waddr; wd2_d = div_wd;
      end
   end

   // Starvation counter, stall flag and scoreboard.
   always_comb begin
      cnt_d = cnt_q;
      if (div_kill || !div_valid || hs)
         cnt_d = '0;
      else if (cnt_q < CNT_MAX)
         cnt_d = cnt_q + 1'b1;

      // Stall rises with the edge on which the counter saturates.
      stall_d = stall_q;
      if (div_kill || hs)
         stall_d = 1'b0;
      else if (cnt_d == CNT_MAX)
         stall_d = 1'b1;

      set_vec = div_issue ? (32'd1 << div_issue_waddr) : 32'd0;
      clr_vec = hs        ? (32'd1 << div_waddr)       : 32'd0;
      // Set is applied after clear so a same-address issue wins.
      busy_d  = div_kill ? 32'd0 : ((busy_q & ~clr_vec) | set_vec);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wen0_q   <= 1'b0;  wen1_q   <= 1'b0;  wen2_q   <= 1'b0;
         waddr0_q <= '0;    waddr1_q <= '0;    waddr2_q <= '0;
         wd0_q    <= '0;    wd1_q    <= '0;    wd2_q    <= '0;
         busy_q   <= '0;
         cnt_q    <= '0;
         stall_q  <= 1'b0;
      end else begin
         wen0_q   <= wen0_d;   wen1_q   <= wen1_d;   wen2_q   <= wen2_d;
         waddr0_q <= waddr0_d; waddr1_q <= waddr1_d; waddr2_q <= waddr2_d;
         wd0_q    <= wd0_d;    wd1_q    <= wd1_d;    wd2_q    <= wd2_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         stall_q  <= stall_d;
      end
   end

   assign wen0 = wen0_q;  assign waddr0 = waddr0_q;  assign wd0 = wd0_q;
   assign wen1 = wen1_q;  assign waddr1 = waddr1_q;  assign wd1 = wd1_q;
   assign wen2 = wen2_q;  assign waddr2 = waddr2_q;  assign wd2 = wd2_q;
   assign busy     = busy_q;
   assign wb_stall = stall_q;

`ifdef ASSERT_ON
   a_fp1_under_stall: assert property (@(posedge clk) disable iff (rst)
      !(stall_q && fp1_wen));
   a_fast_addr_unique: assert property (@(posedge clk) disable iff (rst)
      !((fp0_wen && fp1_wen && fp0_waddr == fp1_waddr) ||
        (fp0_wen && ld_wen  && fp0_waddr == ld_waddr)  ||
        (fp1_wen && ld_wen  && fp1_waddr == ld_waddr)));
   a_issue_not_busy: assert property (@(posedge clk) disable iff (rst)
      !(div_issue && busy_q[div_issue_waddr]));
`endif

endmodule

// File: doc/dec_fpr_wb_ctl.md
Name: dec_fpr_wb_ctl

Overview:
Write-side controller for the floating-point register file. It merges results from three fixed-latency FP sources and one long-latency divide/sqrt unit onto the register file's three write ports (wen0/1/2, waddr0/1/2, wd0/1/2).
It also keeps a 32-entry busy scoreboard for in-flight divide destinations, so decode can stall dependent reads.
It sits between the FP execution/load pipes and the FP register file in dec.

Parameters:
STARVE_MAX, 4, consecutive denied cycles of a pending divide result before wb_stall asserts (1..2**CNT_W-1).
CNT_W, 3, width of the starvation counter.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
fp0_wen  in  1  FPU pipe-0 result valid (no backpressure)
fp0_waddr  in  5  pipe-0 destination
fp0_wd  in  32  pipe-0 data
fp1_wen  in  1  FPU pipe-1 result valid (no backpressure)
fp1_waddr  in  5  pipe-1 destination
fp1_wd  in  32  pipe-1 data
ld_wen  in  1  FP load result valid (no backpressure)
ld_waddr  in  5  load destination
ld_wd  in  32  load data
div_valid  in  1  divide result pending
div_waddr  in  5  divide destination
div_wd  in  32  divide data
div_ready  out  1  divide result accepted this cycle
div_issue  in  1  divide issued at decode
div_issue_waddr  in  5  issued divide destination
div_kill  in  1  flush: in-flight divide cancelled
busy  out  32  per-FPR pending-divide scoreboard
wb_stall  out  1  tells decode to suppress fp1 writeback next cycle
wen0/wen1/wen2  out  1 each  register-file write enables
waddr0/waddr1/waddr2  out  5 each  register-file write addresses
wd0/wd1/wd2  out  32 each  register-file write data

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - wen0..2=0, waddr*=0, wd*=0.
  - busy=0, counter=0, wb_stall=0.
  - div_ready=0 while rst=1.
- Fixed mapping: fp0→port0, fp1→port1, ld→port2.
- Write outputs are registered, 1 cycle latency from a source valid to wenN.
- Divide arbitration (combinational on div_valid):
  - div_ready=1 if div_valid and any of fp0_wen, fp1_wen, ld_wen is 0.
  - The divide takes the lowest-numbered free port (0, then 1, then 2).
  - The handshake completes on the cycle div_valid & div_ready. The divide unit holds div_waddr and div_wd stable until then.
- WAW collision: if the granted divide's address equals any asserted fast-source address in the same cycle, the divide is still consumed (div_ready=1), but its write is suppressed (no wenN). The younger fast write wins.
- Starvation counter:
  - Increments each cycle div_valid & ~div_ready, saturating at STARVE_MAX.
  - Clears on handshake, or when div_valid=0.
- wb_stall:
  - Registered. Set the cycle after the counter reaches STARVE_MAX; cleared the cycle after a handshake.
  - While wb_stall=1, upstream guarantees fp1_wen=0. A violation fires an assertion under ASSERT_ON.
- Scoreboard:
  - div_issue sets busy[div_issue_waddr] next cycle.
  - A handshake clears busy[div_waddr] next cycle, including the suppressed-WAW case.
  - If issue and handshake target the same address in the same cycle, set wins.
  - div_kill clears all busy bits next cycle and resets the counter and wb_stall. A div_valid in the same cycle as div_kill is ignored (div_ready=0).
- Assertions under ASSERT_ON:
  - No two of fp0/fp1/ld assert wen to the same address in one cycle.
  - div_issue never targets an already-busy register.

Test Plan:
- fp0_wen=1, waddr 3, wd 0x3F800000; ld_wen=1, waddr 7, wd 0x40000000 → next cycle wen0=1/waddr0=3/wd0=0x3F800000 and wen2=1/waddr2=7/wd2=0x40000000; wen1=0.
- div_issue to f9, then div_valid (f9, 0x12345678) with only fp0 active → div_ready=1 same cycle; next cycle wen1=1/waddr1=9/wd1=0x12345678 and busy[9] goes 1→0.
- All three fast sources active for 6 cycles with div_valid held → div_ready=0; wb_stall=1 on cycle 5 (STARVE_MAX=4). With fp1_wen=0 afterward, the divide writes via port1 and wb_stall drops the following cycle.
- Divide handshake to f4 in the same cycle ld writes f4 with 0xAAAA5555 → only wen2 asserts (waddr2=4, 0xAAAA5555); div consumed; busy[4] cleared.
- busy[2] and busy[5] set, then div_kill → busy=0 next cycle, counter=0, wb_stall=0; a simultaneous div_valid gives div_ready=0.
- rst=1 mid-stall with busy bits set → next edge: all outputs, busy and wb_stall are 0.
